// File: rtl/thor2022_io_bridge_if.sv
// Bus bundle between the Thor2022 CPU data port, the I/O bridge and its peripherals.
// Signal names follow the bridge's point of view (_i into the bridge, _o out of it).
interface thor2022_io_bridge_if #(
  parameter int unsigned NSLV = 4
) ();

  // CPU side
  logic                 cyc_i;
  logic                 stb_i;
  logic                 we_i;
  logic [15:0]          sel_i;
  logic [31:0]          adr_i;
  logic [127:0]         dat_i;
  logic                 ack_o;
  logic                 err_o;
  logic [127:0]         dat_o;

  // Peripheral side
  logic [NSLV-1:0]      cs_o;
  logic                 pcyc_o;
  logic                 pstb_o;
  logic                 pwe_o;
  logic [3:0]           psel_o;
  logic [31:0]          padr_o;
  logic [31:0]          pdat_o;
  logic [NSLV-1:0]      pack_i;
  logic [NSLV*32-1:0]   pdat_i;

  // The bridge itself
  modport slave (
    input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, pack_i, pdat_i,
    output ack_o, err_o, dat_o, cs_o, pcyc_o, pstb_o, pwe_o, psel_o, padr_o, pdat_o
  );

  // The surrounding system: CPU plus peripheral slots
  modport master (
    output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, pack_i, pdat_i,
    input  ack_o, err_o, dat_o, cs_o, pcyc_o, pstb_o, pwe_o, psel_o, padr_o, pdat_o
  );

endinterface

// File: rtl/thor2022_io_bridge.sv
// Thor2022 128-bit CPU bus to 32-bit peripheral bridge.
// A request is latched in IDLE, decoded to one slot, and split into ascending 32-bit beats,
// one per byte-lane group with any select bit set. Read data is assembled lane by lane.
module thor2022_io_bridge #(
  parameter int unsigned        NSLV = 4,
  parameter logic [NSLV*32-1:0] BASE = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] MASK = {NSLV{32'hFFFFF000}},
  parameter int unsigned        TMO  = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  thor2022_io_bridge_if.slave    bus
);

  localparam int unsigned SlotW   = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [15:0] TmoLast = 16'(TMO - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StGap,
    StResp
  } state_e;

  state_e             r_state;
  logic               r_we;
  logic [15:0]        r_sel;
  logic [31:4]        r_adr;
  logic [127:0]       r_dat;
  logic [3:0]         r_pend;
  logic [SlotW-1:0]   r_slot;
  logic [15:0]        r_tmo;
  logic               r_ack;
  logic               r_err;
  logic [127:0]       r_rdat;

  state_e             w_state_nxt;
  logic [3:0]         w_pend_nxt;
  logic [15:0]        w_tmo_nxt;
  logic               w_ack_nxt;
  logic               w_err_nxt;
  logic [127:0]       w_rdat_nxt;
  logic               w_latch;

  logic [NSLV-1:0]    w_hit;
  logic [SlotW-1:0]   w_req_slot;
  logic [3:0]         w_req_pend;
  logic [1:0]         w_lane;
  logic [3:0]         w_lane_oh;
  logic [6:0]         w_dat_base;
  logic [3:0]         w_sel_base;
  logic [3:0]         w_lane_sel;
  logic [31:0]        w_lane_dat;
  logic               w_pack;
  logic [31:0]        w_pdat;
  logic [NSLV-1:0]    w_cs;

  // Address decode; the descending scan leaves the lowest-index hit in w_req_slot.
  always_comb begin
    w_hit      = '0;
    w_req_slot = '0;
    for (int k = int'(NSLV) - 1; k >= 0; k--) begin
      if ((bus.adr_i & MASK[32*k +: 32]) == (BASE[32*k +: 32] & MASK[32*k +: 32])) begin
        w_hit[k]   = 1'b1;
        w_req_slot = SlotW'(k);
      end
    end
    w_req_pend = {|bus.sel_i[15:12], |bus.sel_i[11:8], |bus.sel_i[7:4], |bus.sel_i[3:0]};
  end

  // Current beat: lowest pending lane, its slices, and the selected slot's ack/data.
  always_comb begin
    w_lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_lane = 2'(i);
      end
    end
    w_lane_oh  = 4'b0001 << w_lane;
    w_dat_base = {w_lane, 5'b00000};
    w_sel_base = {w_lane, 2'b00};
    w_lane_sel = r_sel[w_sel_base +: 4];
    w_lane_dat = r_dat[w_dat_base +: 32];
    w_pack     = 1'b0;
    w_pdat     = '0;
    w_cs       = '0;
    for (int k = 0; k < int'(NSLV); k++) begin
      if (r_slot == SlotW'(k)) begin
        w_pack  = bus.pack_i[k];
        w_pdat  = bus.pdat_i[32*k +: 32];
        w_cs[k] = 1'b1;
      end
    end
  end

  // Next-state logic and all bus outputs, decoded from registered state.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_tmo_nxt   = r_tmo;
    w_ack_nxt   = r_ack;
    w_err_nxt   = r_err;
    w_rdat_nxt  = r_rdat;
    w_latch     = 1'b0;

    bus.pcyc_o  = 1'b0;
    bus.pstb_o  = 1'b0;
    bus.pwe_o   = 1'b0;
    bus.cs_o    = '0;
    bus.psel_o  = '0;
    bus.padr_o  = '0;
    bus.pdat_o  = '0;
    bus.ack_o   = (r_state == StResp) && r_ack;
    bus.err_o   = (r_state == StResp) && r_err;
    bus.dat_o   = r_rdat;

    unique case (r_state)
      StIdle: begin
        if (bus.cyc_i && bus.stb_i) begin
          w_latch    = 1'b1;
          w_pend_nxt = w_req_pend;
          w_tmo_nxt  = '0;
          w_rdat_nxt = '0;
          w_ack_nxt  = 1'b0;
          w_err_nxt  = 1'b0;
          if (!(|w_hit)) begin
            w_state_nxt = StResp;
            w_err_nxt   = 1'b1;
            w_pend_nxt  = '0;
          end else if (bus.sel_i == 16'h0000) begin
            w_state_nxt = StResp;
            w_ack_nxt   = 1'b1;
          end else begin
            w_state_nxt = StAccess;
          end
        end
      end

      StAccess: begin
        bus.pcyc_o = 1'b1;
        bus.pstb_o = 1'b1;
        bus.pwe_o  = r_we;
        bus.cs_o   = w_cs;
        bus.psel_o = w_lane_sel;
        bus.padr_o = {r_adr, w_lane, 2'b00};
        bus.pdat_o = w_lane_dat;
        if (!bus.cyc_i) begin
          // CPU abandoned the cycle: drop everything, including a same-cycle ack.
          w_state_nxt = StIdle;
          w_pend_nxt  = '0;
          w_tmo_nxt   = '0;
        end else if (w_pack) begin
          if (!r_we) begin
            w_rdat_nxt[w_dat_base +: 32] = w_pdat;
          end
          w_pend_nxt = r_pend & ~w_lane_oh;
          w_tmo_nxt  = '0;
          if (|w_pend_nxt) begin
            w_state_nxt = StGap;
          end else begin
            w_state_nxt = StResp;
            w_ack_nxt   = 1'b1;
          end
        end else if (r_tmo == TmoLast) begin
          w_state_nxt = StResp;
          w_err_nxt   = 1'b1;
          w_pend_nxt  = '0;
          w_tmo_nxt   = r_tmo + 16'd1;
        end else begin
          w_tmo_nxt = r_tmo + 16'd1;
        end
      end

      StGap: begin
        bus.pcyc_o = 1'b1;
        bus.cs_o   = w_cs;
        w_tmo_nxt  = '0;
        if (!bus.cyc_i) begin
          w_state_nxt = StIdle;
          w_pend_nxt  = '0;
        end else begin
          w_state_nxt = StAccess;
        end
      end

      StResp: begin
        if (!bus.stb_i) begin
          w_state_nxt = StIdle;
          w_ack_nxt   = 1'b0;
          w_err_nxt   = 1'b0;
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request latch, lane bookkeeping, timeout counter and assembled read data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we   <= 1'b0;
      r_sel  <= '0;
      r_adr  <= '0;
      r_dat  <= '0;
      r_slot <= '0;
      r_pend <= '0;
      r_tmo  <= '0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_rdat <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_tmo  <= w_tmo_nxt;
      r_ack  <= w_ack_nxt;
      r_err  <= w_err_nxt;
      r_rdat <= w_rdat_nxt;
      if (w_latch) begin
        r_we   <= bus.we_i;
        r_sel  <= bus.sel_i;
        r_adr  <= bus.adr_i[31:4];
        r_dat  <= bus.dat_i;
        r_slot <= w_req_slot;
      end
    end
  end

endmodule
